// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO serializer slice.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_GAP_CYCLES = 1;
    localparam int GAP_CNT_W      = 4;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry valid/ready hold register between the word producer and the shifter.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_take,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full
);

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_accept;

    assign w_accept = i_valid && !r_full;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    // NOTE: the payload register is left unreset; r_full guards it, so its contents never matter while empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/piso_serializer.sv
// PISO serializer: valid/ready word in, one bit per clock out, idle gap between words.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of each word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  serial_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

`ifdef PISO_PARITY_EN
    localparam int LAST_IDX = DATA_WIDTH;
`else
    localparam int LAST_IDX = DATA_WIDTH - 1;
`endif
    localparam int BIT_CNT_W = $clog2(LAST_IDX + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(LAST_IDX);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

    state_t                  r_state, w_next_state;
    logic [DATA_WIDTH-1:0]   r_shift, w_shifted;
    logic [BIT_CNT_W-1:0]    r_bit_cnt, w_next_idx;
    logic [GAP_CNT_W-1:0]    r_gap_cnt;
    logic                    r_serial_out, r_out_valid, r_done;
    logic                    w_next_serial, w_next_valid, w_next_done;
    logic                    w_hold_full, w_take, w_last_bit, w_gap_done;
    logic [DATA_WIDTH-1:0]   w_hold_data;
`ifdef PISO_PARITY_EN
    localparam logic [BIT_CNT_W-1:0] PAR_CNT = BIT_CNT_W'(DATA_WIDTH);
    logic                    r_parity;
`endif

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
        return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
    endfunction

    piso_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .i_data  (data_in),
        .i_valid (load_valid),
        .o_ready (load_ready),
        .i_take  (w_take),
        .o_data  (w_hold_data),
        .o_full  (w_hold_full)
    );

    assign w_last_bit = (r_bit_cnt == LAST_CNT);
    assign w_gap_done = (r_gap_cnt == '0);
    assign w_shifted  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
    assign w_next_idx = w_take ? '0 : BIT_CNT_W'(r_bit_cnt + 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_hold_full) begin
                    w_take       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_bit) begin
                    w_next_state = GAP;
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    if (w_hold_full) begin
                        w_take       = 1'b1;
                        w_next_state = SHIFT;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and registered on the same edge.
    always_comb begin
        w_next_serial = 1'b0;
        w_next_valid  = 1'b0;
        w_next_done   = 1'b0;
        if (w_next_state == SHIFT) begin
            w_next_valid  = 1'b1;
            w_next_serial = w_take ? first_bit(w_hold_data) : first_bit(w_shifted);
            w_next_done   = (w_next_idx == LAST_CNT);
`ifdef PISO_PARITY_EN
            if (!w_take && w_next_idx == PAR_CNT) begin
                w_next_serial = r_parity;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_serial_out <= 1'b0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_serial_out <= w_next_serial;
            r_out_valid  <= w_next_valid;
            r_done       <= w_next_done;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else if (w_take) begin
            r_shift   <= w_hold_data;
            r_bit_cnt <= '0;
        end else if (r_state == SHIFT) begin
            if (w_last_bit) begin
                r_gap_cnt <= GAP_LOAD;
            end else begin
                r_shift   <= w_shifted;
                r_bit_cnt <= w_next_idx;
            end
        end else if (r_state == GAP && !w_gap_done) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_take) begin
            r_parity <= ^w_hold_data;
        end
    end
`endif

    assign serial_out = r_serial_out;
    assign out_valid  = r_out_valid;
    assign done       = r_done;
    assign busy       = (r_state != IDLE) || w_hold_full;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter. Feeds the team's 8-bit SIPO receiver, which captures one bit per clock while its in_valid is high, LSB first, then spends one dead cycle presenting the word.
- Accepts a word on a valid/ready handshake and emits it one bit per clock with a per-bit valid.
- Inserts an idle gap between words so the receiver's dead cycle never swallows a bit.
- Sits at the transmit end of the serial link, driven by a byte-producing datapath.

Parameters:
DATA_WIDTH, 8, bits per word (range 2..32)
MSB_FIRST, 0, 0 = bit 0 sent first (matches receiver); 1 = bit DATA_WIDTH-1 first
GAP_CYCLES, 1, idle cycles (out_valid=0) after each word; range 1..15; 0 is illegal (receiver needs its dead cycle)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_WIDTH  parallel word to send
load_valid  input  1  data_in is valid
load_ready  output  1  hold buffer empty; a word is accepted on an edge where load_valid && load_ready
serial_out  output  1  current serial bit
out_valid  output  1  serial_out is a live bit (drives receiver in_valid)
busy  output  1  state != IDLE or hold buffer full
done  output  1  one-cycle pulse coincident with the last bit of a word

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset (async, immediate): serial_out=0, out_valid=0, done=0, busy=0, load_ready=1, hold buffer empty, shift register 0, state IDLE. Reset mid-word aborts the word; partial bits and the buffered word are lost; no done pulse.
- Storage: one-entry hold buffer plus a shift register. load_ready = !hold_full, taken from a register with no combinational path from load_valid. Accept and hold-to-shift transfer therefore never coincide.
- Latency: a word accepted at edge k in IDLE loads the shift register at edge k+1. Its first bit is visible with out_valid=1 after edge k+1. The last bit is visible after edge k+DATA_WIDTH.
- FSM: IDLE, SHIFT, GAP.
  - IDLE: if hold_full, transfer to shift register, clear hold, go to SHIFT; else outputs idle.
  - SHIFT: out_valid=1; bit counter counts 0..DATA_WIDTH-1. On the last bit, done=1. Next state is GAP.
  - GAP: out_valid=0, serial_out=0, for GAP_CYCLES cycles via down-counter. At expiry, if hold_full, transfer and go to SHIFT directly; else go to IDLE.
- Back-to-back throughput: one word per DATA_WIDTH+GAP_CYCLES cycles when load_valid is held high.
- While in SHIFT or GAP, one further word may be accepted into hold. A third word sees load_ready=0 until that transfer.
- data_in is sampled only on the accept edge; later changes are ignored.
- Counter widths: $clog2(DATA_WIDTH) and 4 bits respectively; no wrap beyond range.
- Outputs serial_out, out_valid and done are registered.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined: after the data bits, one extra bit carrying even parity (XOR of the word) is sent with out_valid=1. done moves to the parity bit. Per-word length becomes DATA_WIDTH+1.
- Undefined: no parity bit; DATA_WIDTH bits per word.

Decomposition:
- Package piso_pkg: state enum typedef (IDLE, SHIFT, GAP), default width/gap localparams, GAP counter width constant.
- One natural sub-module: piso_hold_buf. It is the one-entry valid/ready register holding data and full flag. The FSM, counters and shifter stay in the top module.

Test Plan:
- Reset then load 0xA5 (MSB_FIRST=0) -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive out_valid cycles; done on the 8th bit; then 1 idle cycle; busy falls.
- Back-to-back 0x3C then 0xC3 with load_valid held -> 0x3C bits, exactly 1 gap cycle, 0xC3 bits; second accept occurs during the first word; a loopback SIPO receiver yields 0x3C then 0xC3.
- Three words offered continuously -> load_ready low from the 2nd accept until the 2nd word enters SHIFT; no word lost or duplicated.
- Assert reset at bit 4 of 0xFF with a second word buffered -> out_valid=0 and serial_out=0 immediately; after release, no bits emitted until a new load; load_ready=1.
- MSB_FIRST=1, GAP_CYCLES=3, load 0x81 -> 1,0,0,0,0,0,0,1 then 3 idle cycles.
- PISO_PARITY_EN defined: load 0xA5 -> 8 data bits plus parity 0; load 0x07 -> parity 1; done on the parity bit.
